dmem_lsu_master: RTL
====================

Name: dmem_lsu_master

Overview:
- Initiator-side load/store unit that drives the 16-bit single-port data memory. Outputs: access address, write data, write enable, read strobe. Input: combinational read data.
- Converts CPU-side single or burst requests (1–8 words) into per-cycle memory beats.
- Handshakes write data in and read data out with valid/ready.
- Sits between the datapath's MEM stage and the data memory.

Parameters:
- ADDR_W, 16, width of request and memory address.
- DATA_W, 16, data word width.
- LEN_W, 3, burst length field width; a burst is len+1 words (1..8).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_write  in  1  1 = store burst, 0 = load burst.
- req_addr  in  ADDR_W  first word address.
- req_len  in  LEN_W  number of words minus 1.
- wdata_valid  in  1  store data beat present.
- wdata_ready  out  1  unit accepts store beat this cycle.
- wdata  in  DATA_W  store data beat.
- resp_valid  out  1  load data beat held in output register.
- resp_ready  in  1  consumer takes load beat.
- resp_rdata  out  DATA_W  load data beat.
- resp_last  out  1  marks final beat of a load burst.
- done  out  1  one-cycle pulse after final beat of any burst.
- mem_access_addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_write_en  out  1  memory write strobe; memory commits on posedge.
- mem_read  out  1  memory read strobe; mem_read_data is valid in the same cycle.
- mem_read_data  in  DATA_W  combinational read data from memory.

Behaviour:
- Reset (async, immediate): state IDLE.
  - req_ready=1; all other outputs 0.
  - Address register, beat counter and resp register cleared.
  - mem_write_en and mem_read drop asynchronously.
  - A reset mid-burst aborts the burst: no partial done, no further memory beats.
- FSM states: IDLE, WRITE, READ, RESP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr into addr_q and req_len into cnt_q.
  - Go to WRITE if req_write=1, else READ.
- WRITE:
  - wdata_ready=1; mem_write_en=wdata_valid; mem_write_data=wdata; mem_access_addr=addr_q.
  - Each accepted beat: addr_q+1 and cnt_q-1.
  - Beat with cnt_q==0 goes to DONE.
  - No wdata_valid: stall with no write.
- READ:
  - mem_read=1 and mem_access_addr=addr_q for exactly one cycle.
  - mem_read_data captured into resp_rdata at the edge.
  - resp_valid=1 and resp_last=(cnt_q==0) next cycle; go to RESP.
- RESP:
  - mem_read=0. Hold resp_rdata/resp_last until resp_ready.
  - On handshake: if resp_last, go to DONE; else addr_q+1, cnt_q-1, back to READ.
  - Throughput is 1 word per 2 cycles.
- DONE: done=1 for one cycle, then IDLE. req_ready=0 in DONE.
- Address arithmetic:
  - addr_q increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - The 8-word memory decodes only addr[2:0], so bursts crossing index 7 wrap to index 0.
- Mutual exclusion: mem_write_en and mem_read are never high in the same cycle.
- mem_access_addr=0 and mem_write_data=0 whenever no strobe is active.
- req_valid outside IDLE is ignored (req_ready=0).

Decomposition:
- Shared package dmem_pkg: ADDR_W/DATA_W/LEN_W defaults, FSM state encoding (3-bit localparams), memory depth constant 8.
- No sub-module needed: FSM, counter and response register live in one module.
- The bench instantiates the existing data memory as the responder.

Test Plan:
- Single store: req addr=0x0003, len=0, wdata=0xA5A5 presented with req → exactly one mem_write_en pulse at addr 3; mem[3]=0xA5A5; done pulse; req_ready back to 1.
- Store burst with gaps: addr=0x0006, len=3, data 0x1111/0x2222/0x3333/0x4444 with wdata_valid low every other cycle → mem[6],mem[7],mem[0],mem[1] written in order; no write on stall cycles.
- Load burst with backpressure: preload mem[i]=i+0x100, addr=2, len=2, resp_ready low for 3 cycles on beat 2 → resp_rdata 0x102/0x103/0x104; resp_last only on 0x104; mem_read pulses exactly 3 times.
- Address wrap: addr=0xFFFF, len=1 load → mem_access_addr 0xFFFF then 0x0000; data from mem[7] then mem[0].
- Reset mid-burst: assert rst_n=0 during WRITE beat 2 of len=4 → mem_write_en falls same cycle; only beats 0–1 committed; req_ready=1 after release; no done.
- Back-to-back requests: req_valid held high with a store then a load → second accepted only after done; no strobe overlap.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory load/store unit: default widths,
// memory depth and the 3-bit FSM state encoding.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 16;
   localparam int DMEM_DATA_W = 16;
   localparam int DMEM_LEN_W  = 3;
   localparam int DMEM_DEPTH  = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // The 8-word memory only decodes the low address bits.
   function automatic logic [2:0] mem_index(input logic [DMEM_ADDR_W-1:0] addr);
      return addr[2:0];
   endfunction

endpackage

// File: rtl/dmem_lsu_master.sv
// Initiator-side load/store unit for the 16-bit single-port data memory.
// Turns single or burst (1..8 word) requests into one memory beat per cycle
// for stores and one read per two cycles for loads.
//
// Handshakes: every channel (req, wdata, resp) transfers on a rising clock
// edge where valid and ready are both high. A valid source holds its payload
// until that edge; ready never depends on the same channel's valid.
import dmem_pkg::*;

module dmem_lsu_master #(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W,
   parameter int LEN_W  = DMEM_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_last,
   output logic              done,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic [2:0]        state_dbg
);

   logic [2:0]        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rdata_q;
   logic              last_q;

   // FSM, address/beat counter and load response register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  cnt_q   <= req_len;
                  state_q <= req_write ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE: begin
               // Stall with no write until a store beat is offered.
               if (wdata_valid) begin
                  addr_q <= addr_q + 1'b1;
                  cnt_q  <= cnt_q - 1'b1;
                  if (cnt_q == '0) state_q <= ST_DONE;
               end
            end
            ST_READ: begin
               // Memory read data is combinational, so capture it this edge.
               rdata_q <= mem_read_data;
               last_q  <= (cnt_q == '0);
               state_q <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  if (last_q) begin
                     state_q <= ST_DONE;
                  end else begin
                     addr_q  <= addr_q + 1'b1;
                     cnt_q   <= cnt_q - 1'b1;
                     state_q <= ST_READ;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode directly from the state register so the memory strobes
   // fall as soon as reset asserts; address/data are forced to zero when no
   // strobe is active.
   assign req_ready       = (state_q == ST_IDLE);
   assign wdata_ready     = (state_q == ST_WRITE);
   assign mem_write_en    = (state_q == ST_WRITE) && wdata_valid;
   assign mem_read        = (state_q == ST_READ);
   assign mem_access_addr = (mem_write_en || mem_read) ? addr_q : '0;
   assign mem_write_data  = mem_write_en ? wdata : '0;
   assign resp_valid      = (state_q == ST_RESP);
   assign resp_rdata      = rdata_q;
   assign resp_last       = (state_q == ST_RESP) && last_q;
   assign done            = (state_q == ST_DONE);
   assign state_dbg       = state_q;

endmodule
